pc_fetch_ctrl: RTL and testbench



---
 rtl/pc_fetch_ctrl_pkg.sv | 24 ++
 rtl/pc_fetch_ctrl_redirect_buf.sv | 56 +++++
 rtl/pc_fetch_ctrl.sv | 116 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_pkg
// Purpose  : Shared constants for the fetch-stage PC controller.
// Revision : 1.0 - initial release
// ============================================================================
package pc_pkg;

    // Fetch FSM encoding
    localparam logic [1:0] c_ST_BOOT = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;

    // Kind of redirect held in the pending buffer
    localparam logic [1:0] c_KIND_NONE = 2'd0;
    localparam logic [1:0] c_KIND_BR   = 2'd1;
    localparam logic [1:0] c_KIND_EXC  = 2'd2;

    localparam logic [31:0] c_RESET_VECTOR = 32'hbfc00000;
    localparam int          c_INST_BYTES   = 4;

endpackage : pc_pkg
`default_nettype wire

// File: rtl/pc_fetch_ctrl_redirect_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : redirect_buf
// Purpose  : Holds one redirect that arrived while a fetch was outstanding;
//            exceptions always win over branches.
// Revision : 1.0 - initial release
// ============================================================================
module redirect_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_capture,
    input  logic             i_consume,
    input  logic             i_exc_valid,
    input  logic [WIDTH-1:0] i_exc_pc,
    input  logic             i_br_valid,
    input  logic [WIDTH-1:0] i_br_pc,
    output logic             o_pend_valid,
    output logic [WIDTH-1:0] o_pend_pc
);

    logic             r_pend_valid;
    logic [1:0]       r_pend_kind;
    logic [WIDTH-1:0] r_pend_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend_kind  <= c_KIND_NONE;
            r_pend_pc    <= '0;
        end else if (i_capture) begin
            if (i_exc_valid) begin
                r_pend_valid <= 1'b1;
                r_pend_kind  <= c_KIND_EXC;
                r_pend_pc    <= i_exc_pc;
            end else if (i_br_valid && (r_pend_kind != c_KIND_EXC)) begin
                // A buffered exception must survive a younger branch
                r_pend_valid <= 1'b1;
                r_pend_kind  <= c_KIND_BR;
                r_pend_pc    <= i_br_pc;
            end
        end else if (i_consume) begin
            r_pend_valid <= 1'b0;
            r_pend_kind  <= c_KIND_NONE;
        end
    end

    assign o_pend_valid = r_pend_valid;
    assign o_pend_pc    = r_pend_pc;

endmodule : redirect_buf
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch_ctrl
// Purpose  : Fetch-stage program counter with instruction-bus handshake,
//            prioritised redirects and misaligned-PC detection.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_ctrl
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(c_RESET_VECTOR),
    parameter int               INST_BYTES   = c_INST_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             exc_valid,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_pc,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    output logic             inst_discard,
    output logic             ce,
    output logic             fetch_adel,
    output logic             redirect_pending
);

    localparam logic [WIDTH-1:0] c_STEP       = WIDTH'(INST_BYTES);
    localparam logic [WIDTH-1:0] c_ALIGN_MASK = WIDTH'(INST_BYTES - 1);

    logic [1:0]       r_state;
    logic             r_ce;
    logic [WIDTH-1:0] r_pc;

    logic             w_pend_valid;
    logic [WIDTH-1:0] w_pend_pc;
    logic             w_adel;
    logic             w_req;
    logic             w_hs;
    logic             w_redir;
    logic [WIDTH-1:0] w_target;
    logic             w_capture;
    logic             w_take;
    logic [WIDTH-1:0] w_new_pc;

    assign w_adel   = r_ce && ((r_pc & c_ALIGN_MASK) != '0);
    // Once issued, a request stays up until accepted
    assign w_req    = (r_state == c_ST_WAIT) ||
                      ((r_state == c_ST_RUN) && !stall && !w_adel);
    assign w_hs     = w_req && inst_addr_ok;
    assign w_redir  = exc_valid || br_valid;
    assign w_target = exc_valid ? exc_pc : br_pc;

    assign w_capture = w_req && !inst_addr_ok && w_redir;
    assign w_take    = !w_capture && (w_hs || !w_req) && (w_redir || w_pend_valid);
    assign w_new_pc  = w_redir ? w_target : w_pend_pc;

    redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .clk          (clk),
        .rst          (rst),
        .i_capture    (w_capture),
        .i_consume    (w_take),
        .i_exc_valid  (exc_valid),
        .i_exc_pc     (exc_pc),
        .i_br_valid   (br_valid),
        .i_br_pc      (br_pc),
        .o_pend_valid (w_pend_valid),
        .o_pend_pc    (w_pend_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_BOOT;
            r_ce    <= 1'b0;
            r_pc    <= RESET_VECTOR;
        end else begin
            case (r_state)
                c_ST_BOOT: begin
                    r_state <= c_ST_RUN;
                    r_ce    <= 1'b1;
                end
                c_ST_RUN: begin
                    if (w_req && !inst_addr_ok) r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    if (inst_addr_ok) r_state <= c_ST_RUN;
                end
                default: begin
                    r_state <= c_ST_BOOT;
                    r_ce    <= 1'b0;
                end
            endcase

            if (w_take) begin
                r_pc <= w_new_pc;
            end else if (w_hs) begin
                r_pc <= r_pc + c_STEP;
            end
        end
    end

    assign inst_req         = w_req;
    assign inst_addr        = r_pc;
    assign inst_discard     = w_hs && (w_redir || w_pend_valid);
    assign ce               = r_ce;
    assign fetch_adel       = w_adel;
    assign redirect_pending = w_pend_valid;

endmodule : pc_fetch_ctrl
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_ctrl
// Purpose  : Self-checking bench for pc_fetch_ctrl: directed scenarios plus
//            randomized traffic against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        exc_valid = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        br_valid = 1'b0;
    logic [31:0] br_pc = '0;
    logic        inst_addr_ok = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_discard;
    logic        ce;
    logic        fetch_adel;
    logic        redirect_pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: architectural view of the fetch unit
    logic        m_booted;
    logic        m_busy;
    logic [31:0] m_pc;
    logic        m_pend;
    logic        m_pend_exc;
    logic [31:0] m_pend_pc;

    pc_fetch_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .exc_valid        (exc_valid),
        .exc_pc           (exc_pc),
        .br_valid         (br_valid),
        .br_pc            (br_pc),
        .inst_req         (inst_req),
        .inst_addr        (inst_addr),
        .inst_addr_ok     (inst_addr_ok),
        .inst_discard     (inst_discard),
        .ce               (ce),
        .fetch_adel       (fetch_adel),
        .redirect_pending (redirect_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        exc_valid = 1'b0;
        br_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; inst_addr_ok = 1'b0; clear_redirects();
        @(negedge clk);
        n_checks++; if (inst_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", inst_req); end
        n_checks++; if (ce !== 1'b0) begin n_errors++; $display("FAIL reset_ce: got %b want 0", ce); end
        n_checks++; if (inst_addr !== 32'hbfc00000) begin n_errors++; $display("FAIL reset_addr: got %h want bfc00000", inst_addr); end
        n_checks++; if ({inst_discard, fetch_adel, redirect_pending} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {inst_discard, fetch_adel, redirect_pending}); end
        step();
        rst = 1'b0; inst_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++; if (ce !== 1'b0 || inst_req !== 1'b0) begin n_errors++; $display("FAIL boot_cycle: ce=%b req=%b want 0 0", ce, inst_req); end
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (ce !== 1'b1 || inst_req !== 1'b1 || inst_addr !== 32'hbfc00000 + 32'(4 * i)) begin
                n_errors++; $display("FAIL seq_fetch%0d: ce=%b req=%b addr=%h want 1 1 %h", i, ce, inst_req, inst_addr, 32'hbfc00000 + 32'(4 * i));
            end
            step();
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'hbfc0000c) begin n_errors++; $display("FAIL stall_pre: got %h want bfc0000c", inst_addr); end
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (inst_req !== 1'b0 || inst_addr !== 32'hbfc00010) begin n_errors++; $display("FAIL stall_hold%0d: req=%b addr=%h want 0 bfc00010", i, inst_req, inst_addr); end
            step();
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00010) begin n_errors++; $display("FAIL stall_resume: req=%b addr=%h want 1 bfc00010", inst_req, inst_addr); end
        step();
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'hbfc00014) begin n_errors++; $display("FAIL stall_next: got %h want bfc00014", inst_addr); end
        step();
    endtask

    task automatic test_branch_outstanding();
        inst_addr_ok = 1'b0;
        @(negedge clk);
        n_checks++; if (inst_req !== 1'b1 || redirect_pending !== 1'b0) begin n_errors++; $display("FAIL br_os_issue: req=%b pend=%b want 1 0", inst_req, redirect_pending); end
        step();
        br_valid = 1'b1; br_pc = 32'hbfc00100;
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'hbfc00018 || inst_req !== 1'b1) begin n_errors++; $display("FAIL br_os_hold: req=%b addr=%h want 1 bfc00018", inst_req, inst_addr); end
        step();
        clear_redirects();
        @(negedge clk);
        n_checks++; if (redirect_pending !== 1'b1 || inst_addr !== 32'hbfc00018) begin n_errors++; $display("FAIL br_os_pend: pend=%b addr=%h want 1 bfc00018", redirect_pending, inst_addr); end
        step();
        inst_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++; if (inst_discard !== 1'b1) begin n_errors++; $display("FAIL br_os_discard: got %b want 1", inst_discard); end
        step();
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'hbfc00100 || redirect_pending !== 1'b0 || inst_discard !== 1'b0) begin
            n_errors++; $display("FAIL br_os_target: addr=%h pend=%b disc=%b want bfc00100 0 0", inst_addr, redirect_pending, inst_discard);
        end
        step();
    endtask

    task automatic test_priority();
        inst_addr_ok = 1'b0;
        exc_valid = 1'b1; exc_pc = 32'hbfc00380;
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'hbfc00104) begin n_errors++; $display("FAIL prio_start: got %h want bfc00104", inst_addr); end
        step();
        clear_redirects(); br_valid = 1'b1; br_pc = 32'h80000000;
        @(negedge clk);
        n_checks++; if (redirect_pending !== 1'b1) begin n_errors++; $display("FAIL prio_pend: got %b want 1", redirect_pending); end
        step();
        clear_redirects(); inst_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++; if (inst_discard !== 1'b1 || inst_addr !== 32'hbfc00104) begin n_errors++; $display("FAIL prio_accept: disc=%b addr=%h want 1 bfc00104", inst_discard, inst_addr); end
        step();
        stall = 1'b1;
        exc_valid = 1'b1; exc_pc = 32'hbfc00400; br_valid = 1'b1; br_pc = 32'h80000000;
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'hbfc00380 || inst_req !== 1'b0 || inst_discard !== 1'b0) begin
            n_errors++; $display("FAIL prio_exc_win: addr=%h req=%b disc=%b want bfc00380 0 0", inst_addr, inst_req, inst_discard);
        end
        step();
        clear_redirects();
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'hbfc00400 || redirect_pending !== 1'b0) begin n_errors++; $display("FAIL prio_same_cycle: addr=%h pend=%b want bfc00400 0", inst_addr, redirect_pending); end
        step();
    endtask

    task automatic test_misaligned();
        stall = 1'b0; inst_addr_ok = 1'b1;
        br_valid = 1'b1; br_pc = 32'hbfc00102;
        @(negedge clk);
        n_checks++; if (inst_discard !== 1'b1 || inst_addr !== 32'hbfc00400) begin n_errors++; $display("FAIL mis_redirect: disc=%b addr=%h want 1 bfc00400", inst_discard, inst_addr); end
        step();
        clear_redirects();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++; if (fetch_adel !== 1'b1 || inst_req !== 1'b0 || inst_addr !== 32'hbfc00102) begin
                n_errors++; $display("FAIL mis_adel%0d: adel=%b req=%b addr=%h want 1 0 bfc00102", i, fetch_adel, inst_req, inst_addr);
            end
            step();
        end
        exc_valid = 1'b1; exc_pc = 32'hbfc00380;
        @(negedge clk);
        n_checks++; if (inst_discard !== 1'b0 || inst_req !== 1'b0) begin n_errors++; $display("FAIL mis_exc: disc=%b req=%b want 0 0", inst_discard, inst_req); end
        step();
        clear_redirects();
        @(negedge clk);
        n_checks++; if (fetch_adel !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'hbfc00380) begin
            n_errors++; $display("FAIL mis_recover: adel=%b req=%b addr=%h want 0 1 bfc00380", fetch_adel, inst_req, inst_addr);
        end
        step();
    endtask

    task automatic test_wrap();
        inst_addr_ok = 1'b1;
        br_valid = 1'b1; br_pc = 32'hfffffffc;
        @(negedge clk);
        step();
        clear_redirects();
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'hfffffffc || inst_req !== 1'b1) begin n_errors++; $display("FAIL wrap_top: addr=%h req=%b want fffffffc 1", inst_addr, inst_req); end
        step();
        @(negedge clk);
        n_checks++; if (inst_addr !== 32'h00000000) begin n_errors++; $display("FAIL wrap_zero: got %h want 00000000", inst_addr); end
        step();
    endtask

    task automatic test_async_reset();
        inst_addr_ok = 1'b0;
        @(negedge clk);
        step();
        stall = 1'b1;
        @(negedge clk);
        n_checks++; if (inst_req !== 1'b1) begin n_errors++; $display("FAIL wait_ignores_stall: got %b want 1", inst_req); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (inst_req !== 1'b0 || inst_addr !== 32'hbfc00000 || ce !== 1'b0) begin
            n_errors++; $display("FAIL async_rst: req=%b addr=%h ce=%b want 0 bfc00000 0", inst_req, inst_addr, ce);
        end
        step();
        rst = 1'b0; stall = 1'b0; inst_addr_ok = 1'b1;
        @(negedge clk);
        n_checks++; if (ce !== 1'b0) begin n_errors++; $display("FAIL async_boot: ce=%b want 0", ce); end
        step();
        @(negedge clk);
        n_checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin n_errors++; $display("FAIL async_restart: req=%b addr=%h want 1 bfc00000", inst_req, inst_addr); end
        step();
    endtask

    task automatic test_random();
        logic        e_req, e_adel, e_disc, hs, redir;
        logic [31:0] tgt;
        rst = 1'b1; stall = 1'b0; inst_addr_ok = 1'b0; clear_redirects();
        step();
        rst = 1'b0;
        m_booted = 1'b0; m_busy = 1'b0; m_pc = 32'hbfc00000;
        m_pend = 1'b0; m_pend_exc = 1'b0; m_pend_pc = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            stall        = ($urandom_range(0, 3) == 0);
            inst_addr_ok = ($urandom_range(0, 2) != 0);
            exc_valid    = ($urandom_range(0, 9) == 0);
            br_valid     = ($urandom_range(0, 5) == 0);
            exc_pc       = 32'h80000000 | ($urandom & 32'h0000fffc);
            br_pc        = 32'hbfc00000 | ($urandom & 32'h0000fffc) | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
            @(negedge clk);
            redir  = exc_valid || br_valid;
            tgt    = exc_valid ? exc_pc : br_pc;
            e_adel = m_booted && (m_pc % 4 != 0);
            e_req  = m_booted && (m_busy || (!stall && !e_adel));
            hs     = e_req && inst_addr_ok;
            e_disc = hs && (m_pend || redir);
            n_checks++; if ({inst_req, inst_discard, ce, fetch_adel, redirect_pending} !== {e_req, e_disc, m_booted, e_adel, m_pend} || inst_addr !== m_pc) begin
                n_errors++;
                $display("FAIL rand_cyc%0d: req/disc/ce/adel/pend=%b addr=%h want %b %h", cyc,
                         {inst_req, inst_discard, ce, fetch_adel, redirect_pending}, inst_addr,
                         {e_req, e_disc, m_booted, e_adel, m_pend}, m_pc);
            end
            if (e_req && !inst_addr_ok) begin
                if (exc_valid) begin
                    m_pend = 1'b1; m_pend_exc = 1'b1; m_pend_pc = exc_pc;
                end else if (br_valid && !(m_pend && m_pend_exc)) begin
                    m_pend = 1'b1; m_pend_exc = 1'b0; m_pend_pc = br_pc;
                end
            end else if (redir || m_pend) begin
                m_pc = redir ? tgt : m_pend_pc;
                m_pend = 1'b0; m_pend_exc = 1'b0;
            end else if (hs) begin
                m_pc = m_pc + 32'd4;
            end
            m_busy   = e_req && !inst_addr_ok;
            m_booted = 1'b1;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stall();
        test_branch_outstanding();
        test_priority();
        test_misaligned();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pc_fetch_ctrl
`default_nettype wire
